// File: rtl/ram2_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : ram2_responder_if
// Purpose  : RAM2 SRAM address/control pins (EN/OE/WE active-low) with
//            controller (master) and memory (slave) views.
// Revision : 1.0 - initial release
// ============================================================================
interface ram2_responder_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] Ram2Addr;
    logic              Ram2OE;
    logic              Ram2WE;
    logic              Ram2EN;

    modport master (output Ram2Addr, Ram2OE, Ram2WE, Ram2EN);
    modport slave  (input  Ram2Addr, Ram2OE, Ram2WE, Ram2EN);
endinterface
`default_nettype wire

// File: rtl/ram2_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram2_responder
// Purpose  : On-chip memory answering the RAM2 async-SRAM pin protocol, with
//            read/write counters and a sticky protocol-error flag.
//            Optional macro RAM2_ADDR_CHECK_EN rejects accesses whose address
//            bits above MEM_AW-1 are nonzero instead of aliasing them.
// Revision : 1.0 - initial release
// ============================================================================
module ram2_responder #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int MEM_AW = 10
) (
    input  wire logic              clk,
    input  wire logic              rst,
    ram2_responder_if.slave        bus,
    // The bidirectional data pins stay a plain port so tristate resolution
    // happens on an ordinary net.
    inout  wire       [DATA_W-1:0] Ram2Data,
    output logic                   busy,
    output logic                   err,
    output logic      [15:0]       rd_cnt,
    output logic      [15:0]       wr_cnt
);

    localparam int c_DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_W_ACTIVE = 2'd1,
        S_W_COMMIT = 2'd2,
        S_ERROR    = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_err;
    logic [15:0]       r_rd_cnt;
    logic [15:0]       r_wr_cnt;
    logic              r_rd_win_q;
    logic [ADDR_W-1:0] r_wadr;
    logic [DATA_W-1:0] r_wdat;
    logic [DATA_W-1:0] r_rd_q;
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic w_sel;
    logic w_oe;
    logic w_we;
    logic w_rd_win;
    logic w_oor;
    logic w_rd_ok;
    logic w_wr_req;
    logic w_contention;
    logic w_addr_moved;
    logic w_oor_wr;
    logic w_oor_rd;
    logic w_fsm_viol;

    assign w_sel    = !bus.Ram2EN;
    assign w_oe     = !bus.Ram2OE;
    assign w_we     = !bus.Ram2WE;
    assign w_rd_win = w_sel && w_oe && !w_we;

`ifdef RAM2_ADDR_CHECK_EN
    assign w_oor = |bus.Ram2Addr[ADDR_W-1:MEM_AW];
`else
    assign w_oor = 1'b0;
`endif

    assign w_rd_ok      = w_rd_win && !w_oor;
    assign w_wr_req     = w_sel && w_we && !w_oe;
    assign w_contention = w_sel && w_oe && w_we;
    // The full address is compared so that upper-bit movement is caught
    // even when those bits alias away in the array index.
    assign w_addr_moved = (r_state == S_W_ACTIVE) && w_sel && (bus.Ram2Addr != r_wadr);
    assign w_oor_wr     = w_oor && w_sel && w_we;
    assign w_oor_rd     = w_oor && w_rd_win;
    assign w_fsm_viol   = w_contention || w_addr_moved || w_oor_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_cnt   <= 16'd0;
            r_wr_cnt   <= 16'd0;
            r_rd_win_q <= 1'b0;
            r_wadr     <= '0;
            r_wdat     <= '0;
        end else begin
            r_rd_win_q <= w_rd_ok;
            // One count per read window, taken when OE releases.
            if (r_rd_win_q && !w_rd_ok) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
            if (w_fsm_viol || w_oor_rd) begin
                r_err <= 1'b1;
            end
            if (r_state == S_W_COMMIT) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end

            case (r_state)
                // Commit completes unconditionally; a new WE-low cycle
                // sampled here starts the next write back-to-back.
                S_IDLE, S_W_COMMIT: begin
                    if (w_fsm_viol) begin
                        r_state <= S_ERROR;
                        r_busy  <= 1'b0;
                    end else if (w_wr_req) begin
                        r_state <= S_W_ACTIVE;
                        r_busy  <= 1'b1;
                        r_wadr  <= bus.Ram2Addr;
                        r_wdat  <= Ram2Data;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_W_ACTIVE: begin
                    if (!w_sel) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_fsm_viol) begin
                        r_state <= S_ERROR;
                        r_busy  <= 1'b0;
                    end else if (w_we) begin
                        r_state <= S_W_ACTIVE;
                        r_busy  <= 1'b1;
                        r_wadr  <= bus.Ram2Addr;
                        r_wdat  <= Ram2Data;
                    end else begin
                        r_state <= S_W_COMMIT;
                        r_busy  <= 1'b1;
                    end
                end
                S_ERROR: begin
                    r_busy <= 1'b0;
                    if (!w_sel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_ERROR;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Array is not reset; a reset during W_COMMIT leaves r_state at IDLE so
    // no write occurs.
    always_ff @(posedge clk) begin
        if (r_state == S_W_COMMIT) begin
            r_mem[r_wadr[MEM_AW-1:0]] <= r_wdat;
        end
    end

    always_ff @(posedge clk) begin
        r_rd_q <= r_mem[bus.Ram2Addr[MEM_AW-1:0]];
    end

    assign Ram2Data = w_rd_ok ? r_rd_q : {DATA_W{1'bz}};

    assign busy   = r_busy;
    assign err    = r_err;
    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;

endmodule
`default_nettype wire

// File: doc/ram2_responder.md
Name: ram2_responder

Overview:
- Synthesizable responder for the external RAM2 asynchronous-SRAM pin interface (EN/OE/WE active-low, 16-bit bidirectional data).
- Answers the same pin protocol that the CPU-side RAM2 controller drives, backed by an on-chip memory array.
- Used as an FPGA-internal stand-in for the board SRAM and as the memory model in system simulation.
- Tracks read/write activity and flags protocol violations for debug.

Parameters:
ADDR_W, 18, width of Ram2Addr bus
DATA_W, 16, width of Ram2Data bus
MEM_AW, 10, implemented array address bits; depth = 2^MEM_AW, low MEM_AW bits of Ram2Addr index it

Ports:
clk  input  1  system clock, same clock as the RAM2 controller
rst  input  1  asynchronous, active-low reset
Ram2Addr  input  ADDR_W  address from controller
Ram2Data  inout  DATA_W  data bus; driven only during read window, else high-Z
Ram2OE  input  1  output enable, active-low
Ram2WE  input  1  write enable, active-low
Ram2EN  input  1  chip enable, active-low
busy  output  1  high in W_ACTIVE or W_COMMIT
err  output  1  sticky protocol-error flag
rd_cnt  output  16  completed reads, wraps at 0xFFFF->0
wr_cnt  output  16  committed writes, wraps at 0xFFFF->0

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, err=0, rd_cnt=0, wr_cnt=0; Ram2Data=Z. Array contents not reset. Reset mid-write aborts with no commit.
- Read window: rd_win = !Ram2EN && !Ram2OE && Ram2WE, combinational.
- Read data path: rd_q <= mem[Ram2Addr[MEM_AW-1:0]] every posedge.
  - Ram2Data = rd_win ? rd_q : Z.
  - Address must be stable >=1 cycle before OE falls. The controller holds the address from IDLE onward, so data is valid in the cycle OE is low.
- rd_cnt increments on a posedge where rd_win was 1 in the previous cycle and is 0 now (OE release). Counts once per read window, regardless of how many cycles OE stays low.
- Write FSM (all inputs sampled at posedge):
  - IDLE: EN=0, WE=0, OE=1 -> W_ACTIVE; wdat <= Ram2Data; wadr <= Ram2Addr.
  - W_ACTIVE: while WE=0 and EN=0, re-latch wdat and wadr each cycle, so the last-cycle value wins. On WE=1 with EN=0 -> W_COMMIT. On EN=1 -> IDLE, no commit (abort).
  - W_COMMIT (1 cycle): mem[wadr] <= wdat; wr_cnt++; -> IDLE. If WE=0 is sampled here, the new write starts: next state W_ACTIVE with fresh latch (back-to-back writes).
  - ERROR: entered from any state when a violation is sampled. Exit to IDLE when EN=1 is sampled. Never commits.
- Protocol violations; each sets err=1 (sticky until reset):
  - OE=0 and WE=0 sampled together while EN=0: bus contention. Responder does not drive the bus, since rd_win is false.
  - Ram2Addr changes while in W_ACTIVE.
- Simultaneous events:
  - Read window sampled during W_COMMIT: commit completes first. Read data reflects the new value from the next cycle onward. Same-address read-after-write returns wdat one cycle after commit.
  - EN=1 always forces Ram2Data=Z.
- Addresses above 2^MEM_AW-1 alias onto the low bits (without the optional feature).

Optional Feature:
- Macro: RAM2_ADDR_CHECK_EN.
- Defined: an access with any nonzero Ram2Addr bits above MEM_AW-1 is out-of-range.
  - Read: Ram2Data stays Z, rd_cnt unchanged, err=1.
  - Write: FSM goes to ERROR, no commit, err=1.
- Undefined: upper bits are ignored and addresses alias, with no error.

Test Plan:
- Write then read: controller-style write of 0xBEEF at addr 0x00005 (WE low 2 cycles, then WE high), then a read of 0x00005 -> Ram2Data=0xBEEF while OE=0; wr_cnt=1, rd_cnt=1, err=0.
- Back-to-back writes 0x1111@3 then 0x2222@3 with WE high only 1 cycle, then read @3 -> 0x2222; wr_cnt=2.
- Abort: WE low at addr 7 with data 0xAAAA, then EN high before WE rises; read @7 -> old value (0x0000 after preload), wr_cnt unchanged, err=0.
- Contention: EN=0, OE=0, WE=0 for 1 cycle -> err=1, Ram2Data=Z, FSM in ERROR. EN=1 -> IDLE; err stays 1 until rst pulse, then err=0 and both counters 0.
- Reset mid-write: rst low during W_ACTIVE with data 0x5A5A@9 -> no commit, mem[9] unchanged, busy=0 immediately (async).
- Aliasing/check: write 0x1234 @0x00400 (MEM_AW=10). Without RAM2_ADDR_CHECK_EN, read @0x00000 -> 0x1234. With it: err=1, no commit, and read @0x00400 leaves Ram2Data=Z.
